// File: rtl/uart_rx_fifo.sv
// UART receiver with start-glitch rejection, parity/framing checks
// and a first-word fall-through receive FIFO with valid/ready output.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rxd,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);
    localparam logic [NW-1:0] FULL_CNT  = NW'(FIFO_DEPTH);
    localparam logic          HAS_PAR   = (PARITY != 0);
    localparam logic          ODD       = (PARITY == 2);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_BREAK
    } state_t;

    logic                 s1_q;
    logic                 s2_q;
    logic                 rs;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 pbad_q, pbad_d;
    logic                 push_q, push_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;

    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_q, wr_d;
    logic [AW-1:0]        rd_q, rd_d;
    logic [NW-1:0]        count_q, count_d;
    logic [7:0]           hold_q, hold_d;
    logic                 ovr_q, ovr_d;
    logic [7:0]           byte_w;
    logic                 full;
    logic                 pop;
    logic                 do_push;

    // Two-flop synchronizer; reset loads the idle line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= rxd;
            s2_q <= s1_q;
        end
    end

    assign rs = s2_q;

    // Receive FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            pbad_q  <= 1'b0;
            push_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            pbad_q  <= pbad_d;
            push_q  <= push_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state: mid-bit sampling, parity fold and frame verdict.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        pbad_d  = pbad_q;
        push_d  = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!rs) begin
                    cnt_d   = '0;
                    pbad_d  = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rs ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rs, shift_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_LAST) begin
                        stop_d  = 1'b0;
                        state_d = HAS_PAR ? S_PAR : S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PAR: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    pbad_d  = (^shift_q) ^ rs ^ ODD;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (!rs) begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end else if (stop_q == STOP_LAST) begin
                        perr_d  = pbad_q;
                        push_d  = !pbad_q;
                        state_d = S_IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_BREAK: begin
                if (rs) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Zero-extend the assembled character to the byte-wide FIFO.
    always_comb begin
        byte_w                = '0;
        byte_w[DATA_BITS-1:0] = shift_q;
    end

    assign full    = (count_q == FULL_CNT);
    assign pop     = rx_valid && rx_ready;
    assign do_push = push_q && (!full || pop);

    // FIFO storage; written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= byte_w;
        end
    end

    // FIFO pointers, occupancy, last-popped byte and overrun pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            hold_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            hold_q  <= hold_d;
            ovr_q   <= ovr_d;
        end
    end

    // FIFO next-state: simultaneous push and pop leave count unchanged.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        hold_d  = hold_q;
        ovr_d   = push_q && full && !pop;
        if (do_push) begin
            wr_d = wr_q + AW'(1);
        end
        if (pop) begin
            rd_d   = rd_q + AW'(1);
            hold_d = mem_q[rd_q];
        end
        if (do_push && !pop) begin
            count_d = count_q + NW'(1);
        end else if (pop && !do_push) begin
            count_d = count_q - NW'(1);
        end
    end

    assign rx_valid   = (count_q != '0);
    assign rx_data    = rx_valid ? mem_q[rd_q] : hold_q;
    assign fifo_count = count_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != S_IDLE);

endmodule
